// File: rtl/axi_bram_pkg.sv
// Shared types and helpers for the banked-BRAM AXI4 slave.
package axi_bram_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } axi_burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    // Largest divisor of total that does not exceed limit.
    function automatic int max_div_le(input int total, input int limit);
        int best;
        best = 1;
        for (int d = 1; d <= limit; d++) begin
            if (total % d == 0) best = d;
        end
        return best;
    endfunction

endpackage

// File: rtl/axi_interface_if.sv
// AXI4 bundle split into a write-slave view (AW/W/B) and a read-slave view (AR/R).
interface axi_interface_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport wr_slv (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );

    modport rd_slv (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address sequencer for one AXI burst (FIXED / INCR / WRAP).
module axi_burst_addr_gen
    import axi_bram_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BEAT_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        beat_idx,
    output logic              last,
    output logic              illegal
);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(1) << BEAT_SHIFT;
    localparam logic [ADDR_W-1:0] BEAT_MASK  = BEAT_BYTES - ADDR_W'(1);

    logic [7:0]        len_q;
    logic [1:0]        burst_q;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] next_addr;

    always_comb begin
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << BEAT_SHIFT) - ADDR_W'(1);
        case (burst_q)
            FIXED:   next_addr = addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | ((addr + BEAT_BYTES) & wrap_mask);
            default: next_addr = addr + BEAT_BYTES;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            beat_idx <= '0;
            len_q    <= '0;
            burst_q  <= INCR;
        end else if (load) begin
            addr     <= start_addr & ~BEAT_MASK;
            beat_idx <= '0;
            len_q    <= len;
            burst_q  <= burst;
        end else if (step) begin
            addr     <= next_addr;
            beat_idx <= beat_idx + 8'd1;
        end
    end

    assign last    = (beat_idx == len_q);
    assign illegal = (burst_q == 2'b11) ||
                     ((burst_q == WRAP) && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));

endmodule

// File: rtl/axi_bram_slave.sv
// AXI4 memory slave over banked BRAM with independent read and write burst engines.
module axi_bram_slave
    import axi_bram_pkg::*;
#(
    parameter int MEMORY_SIZE_BYTES       = 4096,
    parameter int MEMORY_BLOCK_MAX_ACCESS = 72,
    parameter int MAX_BURST_BEATS         = 256
) (
    input logic             clk,
    input logic             rst,
    axi_interface_if.wr_slv write_slv,
    axi_interface_if.rd_slv read_slv
);
    localparam int ADDR_W     = $bits(read_slv.araddr);
    localparam int DATA_W     = $bits(read_slv.rdata);
    localparam int ID_W       = $bits(read_slv.arid);
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int DEPTH      = MEMORY_SIZE_BYTES / BEAT_BYTES;
    localparam int IDX_W      = $clog2(DEPTH);
    localparam int BANK_W     = max_div_le(DATA_W, MEMORY_BLOCK_MAX_ACCESS);
    localparam int NUM_BANKS  = DATA_W / BANK_W;
    localparam int BANK_BYTES = BANK_W / 8;
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEMORY_SIZE_BYTES);

    // ---------------- read channel ----------------
    r_state_e          r_state, r_state_n;
    logic [ID_W-1:0]   ar_id_q;
    logic              ar_hdr_err_q;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_idx;
    logic              r_last, r_illegal;
    logic              ar_ready, ar_hs, r_valid, r_pop, r_issue, r_issue_done, r_beat_err, mem_re;
    logic              pipe_v, pipe_err, pipe_last;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_resp [2];
    logic              fifo_last [2];
    logic              fifo_wp, fifo_rp;
    logic [1:0]        fifo_cnt, fifo_occ;

    assign ar_hs   = (r_state == R_IDLE) && read_slv.arvalid;
    assign r_valid = (fifo_cnt != 2'd0);
    assign r_pop   = r_valid && read_slv.rready;

    always_comb begin
        r_state_n = r_state;
        ar_ready  = 1'b0;
        case (r_state)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (read_slv.arvalid) r_state_n = R_BURST;
            end
            R_BURST: if (r_pop && fifo_last[fifo_rp]) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
    end

    axi_burst_addr_gen #(.ADDR_W(ADDR_W), .BEAT_SHIFT(BEAT_SHIFT)) u_rd_gen (
        .clk(clk), .rst(rst), .load(ar_hs), .step(r_issue),
        .start_addr(read_slv.araddr), .len(read_slv.arlen), .burst(read_slv.arburst),
        .addr(r_addr), .beat_idx(r_idx), .last(r_last), .illegal(r_illegal)
    );

    // Issue only while the skid FIFO plus the BRAM stage can absorb the result.
    assign fifo_occ   = fifo_cnt + {1'b0, pipe_v};
    assign r_issue    = (r_state == R_BURST) && !r_issue_done && ((fifo_occ != 2'd2) || r_pop);
    assign r_beat_err = ar_hdr_err_q || r_illegal || ({1'b0, r_addr} >= MEM_LIMIT);
    assign mem_re     = r_issue && !r_beat_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= R_IDLE;
            ar_id_q      <= '0;
            ar_hdr_err_q <= 1'b0;
            r_issue_done <= 1'b0;
            pipe_v       <= 1'b0;
            pipe_err     <= 1'b0;
            pipe_last    <= 1'b0;
        end else begin
            r_state <= r_state_n;
            if (ar_hs) begin
                ar_id_q      <= read_slv.arid;
                ar_hdr_err_q <= (read_slv.arsize != 3'(BEAT_SHIFT)) ||
                                (int'(read_slv.arlen) >= MAX_BURST_BEATS);
                r_issue_done <= 1'b0;
            end else if (r_issue && r_last) begin
                r_issue_done <= 1'b1;
            end
            pipe_v    <= r_issue;
            pipe_err  <= r_beat_err;
            pipe_last <= r_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_resp[i] <= RESP_OKAY;
                fifo_last[i] <= 1'b0;
            end
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (pipe_v) begin
                fifo_data[fifo_wp] <= pipe_err ? '0 : rd_word;
                fifo_resp[fifo_wp] <= pipe_err ? RESP_SLVERR : RESP_OKAY;
                fifo_last[fifo_wp] <= pipe_last;
                fifo_wp            <= ~fifo_wp;
            end
            if (r_pop) fifo_rp <= ~fifo_rp;
            fifo_cnt <= fifo_cnt + 2'(pipe_v) - 2'(r_pop);
        end
    end

    assign read_slv.arready = ar_ready;
    assign read_slv.rvalid  = r_valid;
    assign read_slv.rdata   = fifo_data[fifo_rp];
    assign read_slv.rresp   = fifo_resp[fifo_rp];
    assign read_slv.rlast   = r_valid && fifo_last[fifo_rp];
    assign read_slv.rid     = ar_id_q;

    // ---------------- write channel ----------------
    w_state_e          w_state, w_state_n;
    logic [ID_W-1:0]   aw_id_q;
    logic              aw_hdr_err_q, w_err_q;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_idx;
    logic              w_last, w_illegal;
    logic              aw_ready, w_ready, b_valid, aw_hs, w_beat, w_burst_err, w_beat_err, mem_we;

    assign aw_hs       = (w_state == W_IDLE) && write_slv.awvalid;
    assign w_beat      = (w_state == W_DATA) && write_slv.wvalid;
    assign w_burst_err = aw_hdr_err_q || w_illegal;
    assign mem_we      = w_beat && !w_burst_err && ({1'b0, w_addr} < MEM_LIMIT);
    // wlast must coincide with beat awlen; anything else taints the response.
    assign w_beat_err  = w_beat && (({1'b0, w_addr} >= MEM_LIMIT) || (write_slv.wlast != w_last));

    always_comb begin
        w_state_n = w_state;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_ready = 1'b1;
                if (write_slv.awvalid) w_state_n = W_DATA;
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (write_slv.wvalid && write_slv.wlast) w_state_n = W_RESP;
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (write_slv.bready) w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    axi_burst_addr_gen #(.ADDR_W(ADDR_W), .BEAT_SHIFT(BEAT_SHIFT)) u_wr_gen (
        .clk(clk), .rst(rst), .load(aw_hs), .step(w_beat && !w_last),
        .start_addr(write_slv.awaddr), .len(write_slv.awlen), .burst(write_slv.awburst),
        .addr(w_addr), .beat_idx(w_idx), .last(w_last), .illegal(w_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state      <= W_IDLE;
            aw_id_q      <= '0;
            aw_hdr_err_q <= 1'b0;
            w_err_q      <= 1'b0;
        end else begin
            w_state <= w_state_n;
            if (aw_hs) begin
                aw_id_q      <= write_slv.awid;
                aw_hdr_err_q <= (write_slv.awsize != 3'(BEAT_SHIFT)) ||
                                (int'(write_slv.awlen) >= MAX_BURST_BEATS);
                w_err_q      <= 1'b0;
            end else if (w_beat_err) begin
                w_err_q <= 1'b1;
            end
        end
    end

    assign write_slv.awready = aw_ready;
    assign write_slv.wready  = w_ready;
    assign write_slv.bvalid  = b_valid;
    assign write_slv.bid     = aw_id_q;
    assign write_slv.bresp   = (b_valid && (w_err_q || w_burst_err)) ? RESP_SLVERR : RESP_OKAY;

    logic unused_beat_idx;
    assign unused_beat_idx = ^{r_idx, w_idx};

    // ---------------- BRAM banks (read-first) ----------------
    logic [IDX_W-1:0] r_word_idx, w_word_idx;
    assign r_word_idx = r_addr[BEAT_SHIFT +: IDX_W];
    assign w_word_idx = w_addr[BEAT_SHIFT +: IDX_W];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [BANK_W-1:0] bank_mem [DEPTH];
        logic [BANK_W-1:0] bank_q;

        always_ff @(posedge clk) begin
            if (mem_we) begin
                for (int k = 0; k < BANK_BYTES; k++) begin
                    if (write_slv.wstrb[b*BANK_BYTES + k])
                        bank_mem[w_word_idx][k*8 +: 8] <= write_slv.wdata[b*BANK_W + k*8 +: 8];
                end
            end
            if (mem_re) bank_q <= bank_mem[r_word_idx];
        end

        assign rd_word[b*BANK_W +: BANK_W] = bank_q;
    end

endmodule
